muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 152 +++++++++++++++
 tb/tb_muldiv_unit.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one radix-2 step per cycle, fixed
// XLEN+1 cycle latency from the accepting edge to the result_valid_o pulse.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] operand_a_i,
    input  logic [XLEN-1:0] operand_b_i,
    input  logic            kill_i,
    output logic [XLEN-1:0] result_o,
    output logic            result_valid_o,
    output logic            busy_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int CW = (XLEN > 1) ? $clog2(XLEN) : 1;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    logic [1:0]      state;
    logic [CW-1:0]   cnt;
    logic [2:0]      op_q;
    logic            neg_q;
    logic            div0_q;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_mag_q;
    // hi_q: product high half / partial remainder; lo_q: multiplier / quotient
    logic [XLEN-1:0] hi_q;
    logic [XLEN-1:0] lo_q;

    // Operand decode at acceptance
    logic            a_signed, b_signed, a_neg, b_neg, neg_in;
    logic [XLEN-1:0] a_mag, b_mag;

    always_comb begin
        a_signed = (op_i == OP_MULH) || (op_i == OP_MULHSU) ||
                   (op_i == OP_DIV)  || (op_i == OP_REM);
        b_signed = (op_i == OP_MULH) || (op_i == OP_DIV) || (op_i == OP_REM);
        a_neg    = a_signed && operand_a_i[XLEN-1];
        b_neg    = b_signed && operand_b_i[XLEN-1];
        a_mag    = a_neg ? -operand_a_i : operand_a_i;
        b_mag    = b_neg ? -operand_b_i : operand_b_i;
        // Remainder takes the dividend's sign; everything else the XOR of both
        neg_in   = (op_i[2] && op_i[1]) ? a_neg : (a_neg ^ b_neg);
    end

    // One radix-2 step
    logic [XLEN:0]   mul_addend, mul_sum, div_shift, div_diff;
    logic [XLEN-1:0] hi_nxt, lo_nxt;

    always_comb begin
        mul_addend = '0;
        hi_nxt     = hi_q;
        lo_nxt     = lo_q;
        if (lo_q[0]) mul_addend = {1'b0, b_mag_q};
        mul_sum   = {1'b0, hi_q} + mul_addend;
        div_shift = {hi_q, lo_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, b_mag_q};
        if (op_q[2]) begin
            if (!div_diff[XLEN]) begin
                hi_nxt = div_diff[XLEN-1:0];
                lo_nxt = {lo_q[XLEN-2:0], 1'b1};
            end else begin
                hi_nxt = div_shift[XLEN-1:0];
                lo_nxt = {lo_q[XLEN-2:0], 1'b0};
            end
        end else begin
            hi_nxt = mul_sum[XLEN:1];
            lo_nxt = {mul_sum[0], lo_q[XLEN-1:1]};
        end
    end

    // Sign fix-up and result selection, used in DONE
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo_s, rem_s, final_res;

    always_comb begin
        prod_s = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
        quo_s  = neg_q ? -lo_q : lo_q;
        rem_s  = neg_q ? -hi_q : hi_q;
        case (op_q)
            OP_MUL:                       final_res = prod_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              final_res = div0_q ? '1 : quo_s;
            default:                      final_res = div0_q ? a_q : rem_s;
        endcase
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state          <= S_IDLE;
            cnt            <= '0;
            op_q           <= '0;
            neg_q          <= 1'b0;
            div0_q         <= 1'b0;
            a_q            <= '0;
            b_mag_q        <= '0;
            hi_q           <= '0;
            lo_q           <= '0;
            result_o       <= '0;
            result_valid_o <= 1'b0;
        end else begin
            result_valid_o <= (state == S_DONE) && !kill_i;
            if ((state == S_DONE) && !kill_i) result_o <= final_res;
            case (state)
                S_IDLE: begin
                    if (valid_i && !kill_i) begin
                        state   <= S_CALC;
                        cnt     <= CW'(XLEN - 1);
                        op_q    <= op_i;
                        neg_q   <= neg_in;
                        div0_q  <= op_i[2] && (operand_b_i == '0);
                        a_q     <= operand_a_i;
                        b_mag_q <= b_mag;
                        hi_q    <= '0;
                        lo_q    <= a_mag;
                    end
                end
                S_CALC: begin
                    if (kill_i) begin
                        state <= S_IDLE;
                    end else begin
                        hi_q <= hi_nxt;
                        lo_q <= lo_nxt;
                        cnt  <= cnt - 1'b1;
                        if (cnt == '0) state <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign ready_o = (state == S_IDLE);
    assign busy_o  = (state != S_IDLE);

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: hand-computed RV32M vectors, latency,
// kill and mid-operation reset behaviour.
module tb_muldiv_unit;

    localparam int XLEN = 32;

    localparam logic [2:0] MUL    = 3'b000;
    localparam logic [2:0] MULH   = 3'b001;
    localparam logic [2:0] MULHSU = 3'b010;
    localparam logic [2:0] MULHU  = 3'b011;
    localparam logic [2:0] DIV    = 3'b100;
    localparam logic [2:0] DIVU   = 3'b101;
    localparam logic [2:0] REM    = 3'b110;
    localparam logic [2:0] REMU   = 3'b111;

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b0;
    logic            valid_i = 1'b0;
    logic            ready_o;
    logic [2:0]      op_i = '0;
    logic [XLEN-1:0] operand_a_i = '0;
    logic [XLEN-1:0] operand_b_i = '0;
    logic            kill_i = 1'b0;
    logic [XLEN-1:0] result_o;
    logic            result_valid_o;
    logic            busy_o;

    int total = 0;
    int bad   = 0;

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .valid_i        (valid_i),
        .ready_o        (ready_o),
        .op_i           (op_i),
        .operand_a_i    (operand_a_i),
        .operand_b_i    (operand_b_i),
        .kill_i         (kill_i),
        .result_o       (result_o),
        .result_valid_o (result_valid_o),
        .busy_o         (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // Present a request, hold it for the accepting edge, then scramble inputs.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int w = 0;
        @(negedge clk_i);
        while (!ready_o && w < 50) begin
            @(negedge clk_i);
            w++;
        end
        check("ready_before_issue", {31'b0, ready_o}, 32'd1);
        op_i        = op;
        operand_a_i = a;
        operand_b_i = b;
        valid_i     = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        valid_i     = 1'b0;
        op_i        = 3'($urandom);
        operand_a_i = $urandom;
        operand_b_i = $urandom;
    endtask

    // Count edges from the accepting edge to the result pulse.
    task automatic wait_result(input string tag, input logic [31:0] exp);
        int lat = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk_i);
            #1;
            if (result_valid_o) begin
                lat = c;
                break;
            end
        end
        check({tag, "_latency"}, lat, 32'd33);
        if (lat != 0) begin
            check(tag, result_o, exp);
            @(posedge clk_i);
            #1;
            check({tag, "_pulse_width"}, {31'b0, result_valid_o}, 32'd0);
            check({tag, "_hold"}, result_o, exp);
        end
    endtask

    task automatic run(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp);
        issue(op, a, b);
        wait_result(tag, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        #1;
        check("rst_ready", {31'b0, ready_o}, 32'd1);
        check("rst_busy", {31'b0, busy_o}, 32'd0);
        check("rst_valid", {31'b0, result_valid_o}, 32'd0);
        check("rst_result", result_o, 32'd0);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;

        run("mul_7_m3",      MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB);
        run("mul_low",       MUL,    32'h1234_5678,  32'h0000_0010, 32'h2345_6780);
        run("mulhu_max",     MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run("mulh_m1_m1",    MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000);
        run("mulhsu_m1",     MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run("mulh_min_min",  MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000);
        run("div_m7_2",      DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD);
        run("rem_m7_2",      REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF);
        run("div_7_m2",      DIV,    32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD);
        run("rem_7_m2",      REM,    32'd7,          32'hFFFF_FFFE, 32'h0000_0001);
        run("divu_100_7",    DIVU,   32'd100,        32'd7,         32'd14);
        run("remu_100_7",    REMU,   32'd100,        32'd7,         32'd2);
        run("divu_by0",      DIVU,   32'h8000_0000,  32'd0,         32'hFFFF_FFFF);
        run("remu_by0",      REMU,   32'h8000_0000,  32'd0,         32'h8000_0000);
        run("div_m5_by0",    DIV,    32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFF);
        run("rem_m5_by0",    REM,    32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFB);
        run("div_ovf",       DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000);
        run("rem_ovf",       REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000);

        // Kill in IDLE blocks acceptance
        @(negedge clk_i);
        op_i = MUL; operand_a_i = 32'd2; operand_b_i = 32'd3;
        valid_i = 1'b1; kill_i = 1'b1;
        @(posedge clk_i);
        #1;
        check("kill_idle_busy", {31'b0, busy_o}, 32'd0);
        @(negedge clk_i);
        valid_i = 1'b0; kill_i = 1'b0;

        // Kill at CALC cycle 10: previous result (0 from rem_ovf) must persist
        issue(MUL, 32'd3, 32'd5);
        repeat (9) @(posedge clk_i);
        @(negedge clk_i);
        kill_i = 1'b1;
        @(posedge clk_i);
        #1;
        check("kill_ready", {31'b0, ready_o}, 32'd1);
        check("kill_busy", {31'b0, busy_o}, 32'd0);
        check("kill_valid", {31'b0, result_valid_o}, 32'd0);
        check("kill_result", result_o, 32'h0000_0000);
        @(negedge clk_i);
        kill_i = 1'b0;
        run("after_kill", MUL, 32'd6, 32'd7, 32'd42);

        // Reset mid-CALC with a new request already presented
        issue(DIV, 32'hFFFF_FFF9, 32'd2);
        repeat (5) @(posedge clk_i);
        @(negedge clk_i);
        op_i = DIVU; operand_a_i = 32'd100; operand_b_i = 32'd7;
        valid_i = 1'b1;
        rst_ni  = 1'b0;
        #1;
        check("midrst_ready", {31'b0, ready_o}, 32'd1);
        check("midrst_busy", {31'b0, busy_o}, 32'd0);
        check("midrst_valid", {31'b0, result_valid_o}, 32'd0);
        check("midrst_result", result_o, 32'd0);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        check("postrst_accept", {31'b0, busy_o}, 32'd1);
        @(negedge clk_i);
        valid_i = 1'b0;
        wait_result("postrst_divu", 32'd14);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
